// File: rtl/l1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_pkg
// Description : Shared widths, types and helpers for the L1 fill writer.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int WAYS            = 8;
    localparam int WD_WIDTH        = WAYS * DATA_WIDTH;
    localparam int BEAT_WIDTH      = 256;
    localparam int BEATS_PER_HALF  = WD_WIDTH / BEAT_WIDTH;
    localparam int BEATS_PER_LINE  = 2 * BEATS_PER_HALF;

    localparam int L1_NSTRMS       = 16;
    localparam int L1_NSTRMS_WIDTH = $clog2(L1_NSTRMS);
    localparam int L1_NCL          = 16;
    localparam int L1_NCL_WIDTH    = $clog2(L1_NCL);
    localparam int ADDR_WIDTH      = L1_NSTRMS_WIDTH + L1_NCL_WIDTH + 1;

    typedef logic [L1_NSTRMS_WIDTH-1:0]        strm_t;
    typedef logic [L1_NCL_WIDTH-1:0]           cl_t;
    typedef logic [L1_NCL_WIDTH:0]             occ_t;
    typedef logic [$clog2(BEATS_PER_LINE)-1:0] beat_t;

    // BRAM write address layout: {stream, slot, half}
    typedef struct packed {
        strm_t st;
        cl_t   cl;
        logic  half;
    } wa_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Next ring slot; the ring size is a power of two so the add wraps.
    function automatic cl_t cl_inc(input cl_t c);
        return c + cl_t'(1);
    endfunction

endpackage : l1_pkg
`default_nettype wire

// File: rtl/l1_ring_ctr.sv
`default_nettype none
// ============================================================================
// Module      : l1_ring_ctr
// Description : Per-stream ring write pointer and line occupancy registers.
//               Reserve bumps occupancy, release drops it, advance moves the
//               write pointer. Releasing an empty ring raises a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_ring_ctr
    import l1_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rsv_v,
    input  strm_t                 rsv_st,
    input  logic                  rel_v,
    input  strm_t                 rel_st,
    input  logic                  adv_v,
    input  strm_t                 adv_st,
    output cl_t [L1_NSTRMS-1:0]   wp,
    output logic [L1_NSTRMS-1:0]  full,
    output logic                  err
);

    occ_t                 occ [L1_NSTRMS];
    logic [L1_NSTRMS-1:0] underflow;

    // Decode full flags and empty-ring releases per stream.
    always_comb begin
        full      = '0;
        underflow = '0;
        for (int s = 0; s < L1_NSTRMS; s++) begin
            full[s]      = (occ[s] == occ_t'(L1_NCL));
            underflow[s] = rel_v && (rel_st == strm_t'(s)) &&
                           !(rsv_v && (rsv_st == strm_t'(s))) &&
                           (occ[s] == '0);
        end
    end

    // Occupancy and write-pointer update; a same-stream reserve and release
    // cancel each other out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < L1_NSTRMS; s++) begin
                occ[s] <= '0;
                wp[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < L1_NSTRMS; s++) begin
                if (rsv_v && (rsv_st == strm_t'(s)) &&
                    !(rel_v && (rel_st == strm_t'(s)))) begin
                    if (occ[s] != occ_t'(L1_NCL)) begin
                        occ[s] <= occ[s] + occ_t'(1);
                    end
                end else if (rel_v && (rel_st == strm_t'(s)) &&
                             !(rsv_v && (rsv_st == strm_t'(s)))) begin
                    if (occ[s] != '0) begin
                        occ[s] <= occ[s] - occ_t'(1);
                    end
                end
                if (adv_v && (adv_st == strm_t'(s))) begin
                    wp[s] <= cl_inc(wp[s]);
                end
            end
        end
    end

    // Sticky error once any stream is released while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (|underflow) begin
            err <= 1'b1;
        end
    end

endmodule : l1_ring_ctr
`default_nettype wire

// File: rtl/l1_fill_writer.sv
`default_nettype none
// ============================================================================
// Module      : l1_fill_writer
// Description : Packs 256b response beats into 512b half-lines, allocates
//               each 128B line to the stream's next ring slot, drives the
//               BRAM write port and announces completed lines.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_fill_writer
    import l1_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_v,
    output logic                       i_r,
    input  logic [L1_NSTRMS_WIDTH-1:0] i_st,
    input  logic [BEAT_WIDTH-1:0]      i_d,
    input  logic                       i_rel_v,
    input  logic [L1_NSTRMS_WIDTH-1:0] i_rel_st,
    output logic                       o_we,
    output logic [ADDR_WIDTH-1:0]      o_wa,
    output logic [WD_WIDTH-1:0]        o_wd,
    output logic                       o_fill_v,
    output logic [L1_NSTRMS_WIDTH-1:0] o_fill_st,
    output logic [L1_NCL_WIDTH-1:0]    o_fill_cl,
    output logic                       o_err
);

    state_t                state;
    beat_t                 beat_cnt;
    strm_t                 cur_st;
    cl_t                   cur_cl;
    logic [BEAT_WIDTH-1:0] pack_lo;
    wa_t                   wa_q;

    cl_t [L1_NSTRMS-1:0]   wp;
    logic [L1_NSTRMS-1:0]  full;
    logic                  accept;
    logic                  rsv_v;
    logic                  adv_v;

    // Ready: beat 0 waits for a free slot; later beats always flow.
    always_comb begin
        i_r = (state == ST_IDLE) ? !full[i_st] : 1'b1;
    end

    assign accept = i_v && i_r;
    assign rsv_v  = accept && (state == ST_IDLE);
    assign adv_v  = accept && (state == ST_FILL) &&
                    (beat_cnt == beat_t'(BEATS_PER_LINE - 1));
    assign o_wa   = wa_q;

    l1_ring_ctr u_ring (
        .clk    (clk),
        .reset  (reset),
        .rsv_v  (rsv_v),
        .rsv_st (i_st),
        .rel_v  (i_rel_v),
        .rel_st (i_rel_st),
        .adv_v  (adv_v),
        .adv_st (cur_st),
        .wp     (wp),
        .full   (full),
        .err    (o_err)
    );

    // Line FSM: odd beats close a half and issue its write the next cycle;
    // the last beat also announces the completed line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            cur_st    <= '0;
            cur_cl    <= '0;
            pack_lo   <= '0;
            wa_q      <= '0;
            o_we      <= 1'b0;
            o_wd      <= '0;
            o_fill_v  <= 1'b0;
            o_fill_st <= '0;
            o_fill_cl <= '0;
        end else begin
            o_we     <= 1'b0;
            o_fill_v <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        cur_st   <= i_st;
                        cur_cl   <= wp[i_st];
                        pack_lo  <= i_d;
                        beat_cnt <= beat_t'(1);
                        state    <= ST_FILL;
                    end
                    ST_FILL: begin
                        beat_cnt <= beat_cnt + beat_t'(1);
                        if (!beat_cnt[0]) begin
                            pack_lo <= i_d;
                        end else begin
                            o_we    <= 1'b1;
                            wa_q    <= '{st: cur_st, cl: cur_cl, half: beat_cnt[1]};
                            o_wd    <= {i_d, pack_lo};
                            if (beat_cnt[1]) begin
                                o_fill_v  <= 1'b1;
                                o_fill_st <= cur_st;
                                o_fill_cl <= cur_cl;
                                state     <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        beat_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule : l1_fill_writer
`default_nettype wire
